// File: rtl/mux4way16_arb_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter around MUX4WAY16.
//   arb_state_e : arbiter FSM state (IDLE / BUSY)
//   N, SEL_W    : requester count and select width (fixed at 4 / 2)
//   next_ptr()  : round-robin successor of a requester index
package mux4way16_arb_pkg;

  localparam int N     = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Two-bit add wraps 3 -> 0 on its own.
  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] sel);
    return sel + 2'd1;
  endfunction

endpackage

// File: rtl/MUX4WAY16.sv
// Four-input data multiplexer.
//   a, b, c, d : data inputs
//   sel[1:0]   : 0=a, 1=b, 2=c, 3=d
//   out        : selected input
module MUX4WAY16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    case (sel)
      2'd0:    out = a;
      2'd1:    out = b;
      2'd2:    out = c;
      default: out = d;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker over four request lines.
//   req[3:0] : request bits
//   ptr[1:0] : highest-priority index; scan order ptr, ptr+1, ... (mod 4)
//   any      : at least one request is set
//   idx[1:0] : first set request in scan order (ptr when any=0)
module rr_pick4
  import mux4way16_arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    any  = 1'b0;
    idx  = ptr;
    cand = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux4way16_arbiter.sv
// Round-robin arbiter sharing one MUX4WAY16 among four valid/ready/last
// requesters; the grant is held until the granted requester's last beat is
// accepted. Output beat is registered with a valid/ready handshake.
//   clk, rst_n         : clock, async active-low reset
//   req_valid/req_last : per-requester beat valid / final-beat flag (bit0=a)
//   a, b, c, d         : requester data
//   req_ready          : per-requester accept, one-hot or zero
//   out_valid/out_data : registered output beat
//   out_sel            : requester index that produced out_data
//   out_ready          : sink accepts the beat
//
// state | meaning
// IDLE  | no grant; pick next requester from ptr, latch into gsel
// BUSY  | grant held on gsel until its last beat transfers
module mux4way16_arbiter
  import mux4way16_arb_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid,
  input  logic [N-1:0]     req_last,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [N-1:0]     req_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SEL_W-1:0] out_sel,
  input  logic             out_ready
);

  arb_state_e       state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt;
  logic [SEL_W-1:0] gsel, gsel_nxt;
  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic [WIDTH-1:0] mux_y;
  logic             xfer;

  rr_pick4 u_pick (
    .req (req_valid),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  MUX4WAY16 #(.WIDTH(WIDTH)) u_mux (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .sel (gsel),
    .out (mux_y)
  );

  // Accept only when the output register is empty or draining this cycle.
  assign req_ready = (state == BUSY && (!out_valid || out_ready))
                     ? ({{(N-1){1'b0}}, 1'b1} << gsel) : '0;
  assign xfer      = req_valid[gsel] & req_ready[gsel];

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gsel_nxt  = gsel;
    case (state)
      IDLE: begin
        if (pick_any) begin
          gsel_nxt  = pick_idx;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (xfer && req_last[gsel]) begin
          state_nxt = IDLE;
          ptr_nxt   = next_ptr(gsel);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      gsel  <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gsel  <= gsel_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_y;
      out_sel   <= gsel;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
